// File: rtl/keypad_scanner.sv
// Keypad row scanner with press/release debounce.
// Feeds a stable one-hot row/column pair to the keypad decoder.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] col_in,
    output logic [3:0] row_drv,
    output logic [3:0] key_rows,
    output logic [2:0] key_cols,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit FAST_ACC = (DEBOUNCE_CNT == 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    col_m;
    logic [2:0]    col_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    cand_row;
    logic [2:0]    cand_col;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] rel_cnt;
    logic [CW-1:0] deb_inc;
    logic [CW-1:0] rel_inc;
    logic          col_one;
    logic          col_none;
    logic          col_match;
    logic          capture;
    logic          accept;
    logic          bounce;
    logic          rel_done;
    logic          advance;
    logic [3:0]    acc_row;
    logic [2:0]    acc_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= '0;
            col_s <= '0;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick      = (div_cnt == DIV_LAST);
    assign col_none  = (col_s == 3'b000);
    assign col_one   = (col_s == 3'b001) || (col_s == 3'b010) ||
                       (col_s == 3'b100);
    assign col_match = (col_s == cand_col);
    assign deb_inc   = deb_cnt + CNT_ONE;
    assign rel_inc   = rel_cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (col_one) begin
                        state_nxt = FAST_ACC ? HELD : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!col_match) begin
                        state_nxt = SCAN;
                    end else if (deb_inc == CNT_DONE) begin
                        state_nxt = HELD;
                    end
                end
                HELD: begin
                    if (col_none && (rel_inc == CNT_DONE)) begin
                        state_nxt = SCAN;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    always_comb begin
        capture  = tick && (state == SCAN) && col_one;
        bounce   = tick && (state == DEBOUNCE) && !col_match;
        accept   = (capture && FAST_ACC) ||
                   (tick && (state == DEBOUNCE) && col_match &&
                    (deb_inc == CNT_DONE));
        rel_done = tick && (state == HELD) && col_none &&
                   (rel_inc == CNT_DONE);
        advance  = (tick && (state == SCAN) && !col_one) ||
                   bounce || rel_done;
        // A single-tick accept comes straight from the live scan values
        acc_row  = (state == SCAN) ? row_drv : cand_row;
        acc_col  = (state == SCAN) ? col_s : cand_col;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_drv   <= 4'b1000;
            cand_row  <= '0;
            cand_col  <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_rows  <= '0;
            key_cols  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= accept;
            if (advance) begin
                row_drv <= {row_drv[0], row_drv[3:1]};
            end
            if (capture) begin
                cand_row <= row_drv;
                cand_col <= col_s;
            end
            if (accept || bounce) begin
                deb_cnt <= '0;
            end else if (capture) begin
                deb_cnt <= CNT_ONE;
            end else if (tick && (state == DEBOUNCE)) begin
                deb_cnt <= deb_inc;
            end
            if (tick && (state == HELD)) begin
                rel_cnt <= (col_none && !rel_done) ? rel_inc : '0;
            end
            if (accept) begin
                key_rows <= acc_row;
                key_cols <= acc_col;
                key_held <= 1'b1;
            end else if (rel_done) begin
                key_rows <= '0;
                key_cols <= '0;
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a row-gated keypad model.
// SCAN_DIV=8, DEBOUNCE_CNT=3; ticks land on every 8th cycle after reset.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [2:0] col_in;
    logic [3:0] row_drv;
    logic [3:0] key_rows;
    logic [2:0] key_cols;
    logic       key_valid;
    logic       key_held;

    logic [3:0] k_row;
    logic [2:0] k_col;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int vcount  = 0;
    int base;

    keypad_scanner #(
        .SCAN_DIV    (8),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col_in   (col_in),
        .row_drv  (row_drv),
        .key_rows (key_rows),
        .key_cols (key_cols),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: the held key only shows on the columns while its row is driven
    assign col_in = (row_drv == k_row) ? k_col : 3'b000;

    always @(posedge clk) begin
        if (key_valid) vcount <= vcount + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_held"}, 32'(key_held), 32'd0);
        check({tag, "_rows"}, 32'(key_rows), 32'd0);
        check({tag, "_cols"}, 32'(key_cols), 32'd0);
    endtask

    initial begin
        k_row = 4'b0000;
        k_col = 3'b000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_row", 32'(row_drv), 32'h8);
        check("rst_valid", 32'(key_valid), 32'd0);
        chk_idle("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        // Scan rotation with no key
        at(1);  check("scan_r1", 32'(row_drv), 32'h8);
        at(7);  check("scan_r7", 32'(row_drv), 32'h8);
        at(8);  check("scan_r8", 32'(row_drv), 32'h4);
        at(16); check("scan_r16", 32'(row_drv), 32'h2);
        at(24); check("scan_r24", 32'(row_drv), 32'h1);
        at(32); check("scan_r32", 32'(row_drv), 32'h8);
        chk_idle("scan");
        check("scan_cnt", 32'(vcount), 32'd0);

        // Clean press on row 0100, column 010
        base = vcount;
        k_row = 4'b0100;
        k_col = 3'b010;
        at(48); check("press_frz48", 32'(row_drv), 32'h4);
        at(63); check("press_v63", 32'(key_valid), 32'd0);
        at(64);
        check("press_v64", 32'(key_valid), 32'd1);
        check("press_rows", 32'(key_rows), 32'h4);
        check("press_cols", 32'(key_cols), 32'h2);
        check("press_held", 32'(key_held), 32'd1);
        at(65); check("press_v65", 32'(key_valid), 32'd0);
        at(100);
        check("hold_row", 32'(row_drv), 32'h4);
        check("hold_held", 32'(key_held), 32'd1);

        // Release: three zero ticks at 104, 112, 120
        k_row = 4'b0000;
        at(119); check("rel_held119", 32'(key_held), 32'd1);
        at(120);
        chk_idle("rel");
        check("rel_row", 32'(row_drv), 32'h2);
        check("rel_cnt", 32'(vcount - base), 32'd1);

        // Bounce: captured on tick 128, gone by tick 136
        base = vcount;
        k_row = 4'b0010;
        k_col = 3'b001;
        at(128); check("bnc_frz", 32'(row_drv), 32'h2);
        at(129); k_row = 4'b0000;
        at(136);
        check("bnc_row", 32'(row_drv), 32'h1);
        check("bnc_held", 32'(key_held), 32'd0);

        // Two columns at once on row 1000 are ignored
        k_row = 4'b1000;
        k_col = 3'b011;
        at(144); check("mk_r144", 32'(row_drv), 32'h8);
        at(152);
        check("mk_r152", 32'(row_drv), 32'h4);
        check("mk_held", 32'(key_held), 32'd0);
        check("mk_cnt", 32'(vcount - base), 32'd0);

        // Single key on row 1000, column 100
        k_col = 3'b100;
        at(199); check("k1_v199", 32'(key_valid), 32'd0);
        at(200);
        check("k1_v200", 32'(key_valid), 32'd1);
        check("k1_rows", 32'(key_rows), 32'h8);
        check("k1_cols", 32'(key_cols), 32'h4);
        check("k1_held", 32'(key_held), 32'd1);

        // Asynchronous reset while the key is held
        at(210);
        #2 rst_n = 1'b0;
        #1;
        check("ar_row", 32'(row_drv), 32'h8);
        check("ar_valid", 32'(key_valid), 32'd0);
        chk_idle("ar");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        base = vcount;
        at(8);  check("re_frz8", 32'(row_drv), 32'h8);
        at(23); check("re_v23", 32'(key_valid), 32'd0);
        at(24);
        check("re_v24", 32'(key_valid), 32'd1);
        check("re_rows", 32'(key_rows), 32'h8);
        check("re_cols", 32'(key_cols), 32'h4);
        at(25); check("re_v25", 32'(key_valid), 32'd0);
        at(48);
        check("re_held", 32'(key_held), 32'd1);
        check("re_cnt", 32'(vcount - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the keypad number decoder.
- Drives the 4 keypad rows one-hot in rotation and samples the 3 raw column lines.
- Debounces key press and key release.
- Presents a stable one-hot {key_rows, key_cols} pair to the decoder, plus a single-cycle key_valid per accepted press; key_cols is all-zero whenever no key is held, so the decoder's column-OR flag tracks key_held.

Parameters:
- SCAN_DIV, 1000: clock cycles per row dwell; must be >= 4.
- DEBOUNCE_CNT, 4: consecutive matching scan ticks required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- col_in  input  3  raw keypad columns, active-high, asynchronous to clk.
- row_drv  output  4  row strobe, one-hot, active-high, to the keypad.
- key_rows  output  4  one-hot row of the accepted key; 0 when no key is held.
- key_cols  output  3  one-hot column of the accepted key; 0 when no key is held.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high while an accepted key remains held.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: row_drv=4'b1000, key_rows=0, key_cols=0, key_valid=0, key_held=0, state=SCAN, all counters 0. Reset asserted mid-operation clears every output immediately (asynchronously).
- Input synchronisation: col_in passes through a 2-flop synchroniser; col_s below is the synchronised value.
- Divider: counts 0..SCAN_DIV-1 continuously in every state and wraps. tick is high when the divider equals SCAN_DIV-1.
- Row rotation: on a tick, only in SCAN, and only when no key is captured, row_drv rotates 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- Sampling: col_s is evaluated only on tick cycles.
- SCAN state (tick, col_s==0): advance row.
- SCAN state (tick, col_s not one-hot and not zero): multi-key; ignore and advance row.
- SCAN state (tick, col_s one-hot): capture cand_row=row_drv and cand_col=col_s; set deb_cnt=1; freeze row_drv; go to DEBOUNCE.
- DEBOUNCE state (tick, col_s==cand_col): deb_cnt++. When deb_cnt reaches DEBOUNCE_CNT:
  - key_rows<=cand_row and key_cols<=cand_col;
  - key_held<=1 and key_valid<=1 for exactly one cycle;
  - go to HELD.
- DEBOUNCE with DEBOUNCE_CNT==1: the capture tick itself completes acceptance.
- DEBOUNCE state (tick, col_s!=cand_col): clear deb_cnt, return to SCAN, advance row. No output change.
- HELD state (row frozen):
  - tick with col_s==0: rel_cnt++.
  - tick with col_s!=0: rel_cnt=0, including a different column (rollover is ignored; no new key_valid).
  - When rel_cnt reaches DEBOUNCE_CNT: key_rows=0, key_cols=0, key_held=0; rel_cnt=0; go to SCAN and advance row on that same tick.
- Timing of key_valid: registered; asserted in the cycle after the accepting tick. key_rows, key_cols and key_held update in that same cycle.
- Press count: exactly one key_valid per debounced press, regardless of hold length.
- Counter widths: divider is $clog2(SCAN_DIV) bits; deb_cnt and rel_cnt are $clog2(DEBOUNCE_CNT+1) bits; neither saturates past DEBOUNCE_CNT.

Test Plan:
- Test parameters: SCAN_DIV=8, DEBOUNCE_CNT=3. The keypad model drives col_in=K_col only while row_drv==K_row.
1. Reset/scan: release rst_n with no key -> row_drv steps 1000, 0100, 0010, 0001, 1000 every 8 cycles; key_valid, key_held, key_rows and key_cols stay 0.
2. Clean press: key at row 0100 / col 010 held -> capture on first tick with row_drv=0100. Two ticks later (16 cycles), key_valid pulses for 1 cycle with key_rows=0100, key_cols=010, key_held=1; the decoder shows 5. row_drv stays 0100 while held.
3. Bounce: col_in=001 on capture tick, 000 on next tick -> no key_valid; row advances to the next row.
4. Release: after test 2, drop key -> key_held=0 and key_cols=000 one cycle after the 3rd consecutive zero tick; scan resumes at 0010. A 40-cycle hold produced exactly one key_valid.
5. Multi-key: col_in=011 while row 1000 is driven -> no capture, row advances; then single key 1000/100 -> key_valid with key_cols=100 (decoder shows 1).
6. Reset mid-HELD: assert rst_n low asynchronously between clock edges -> all outputs reset immediately and row_drv=1000; after release, the still-held key is re-accepted with one key_valid.
